// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the 1-to-2 buffered demultiplexer:
//   - slot_state_e : one-entry slot state (EMPTY=1'b0, FULL=1'b1)
//   - DEMUX_WIDTH  : default data width (32)
//   - CNT_WIDTH    : width of the optional per-port transfer counters (16)
//   - cnt_next     : counter increment helper, wraps 0xFFFF -> 0x0000
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DEMUX_WIDTH = 32;
    localparam int CNT_WIDTH   = 16;

    // Natural modulo-2^16 increment; the wrap from all-ones to zero is intended.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry output slot of the demultiplexer: state bit plus data register.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset (slot EMPTY, data 0)
//     load  - write din into the slot this cycle (caller guarantees space)
//     ready - downstream accept for this port
//     din   - word to load
//     dout  - held word, 0 while EMPTY
//     valid - slot is FULL
//     drain - output-side transfer happens this cycle (combinational)
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             drain
);

    slot_state_e      state_r;
    slot_state_e      state_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;
    logic             drain_s;

    // Output-side transfer: slot holds a word and the consumer takes it.
    always_comb begin
        drain_s = (state_r == FULL) && ready;
    end

    // Next-state and next-data; a load wins over a drain so a simultaneous
    // drain+load keeps the slot FULL with the new word.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        case (state_r)
            EMPTY: begin
                if (load) begin
                    state_s = FULL;
                    data_s  = din;
                end else begin
                    state_s = EMPTY;
                    data_s  = {WIDTH{1'b0}};
                end
            end
            FULL: begin
                if (load) begin
                    state_s = FULL;
                    data_s  = din;
                end else if (drain_s) begin
                    state_s = EMPTY;
                    data_s  = {WIDTH{1'b0}};
                end else begin
                    state_s = FULL;
                    data_s  = data_r;
                end
            end
            default: begin
                state_s = EMPTY;
                data_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // Slot state and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
        end
    end

    assign dout  = data_r;
    assign valid = (state_r == FULL);
    assign drain = drain_s;

endmodule

// File: rtl/demux32_1_2_buf.sv
// demux32_1_2_buf
//   1-to-2 demultiplexer with a one-entry buffer per destination port and
//   valid/ready handshakes on all sides. Latency is one cycle.
//   Optional feature: define DEMUX32_XFER_CNT_EN to add 16-bit per-port
//   output-transfer counters cnt0/cnt1.
//   Ports:
//     clk, rst               - clock (rising edge), synchronous active-high reset
//     a, s, in_valid         - source word, destination select, source valid
//     in_ready               - source accept (combinational)
//     out0/out1              - destination data (0 while the slot is empty)
//     out0_valid/out1_valid  - destination valid
//     out0_ready/out1_ready  - destination accept
//     cnt0/cnt1              - output transfer counters (only with the macro)
module demux32_1_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic                 s,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic                 out0_valid,
    output logic                 out1_valid,
    input  logic                 out0_ready,
    input  logic                 out1_ready
`ifdef DEMUX32_XFER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic in_ready_s;
    logic load0_s;
    logic load1_s;
    logic drain0_s;
    logic drain1_s;

    // Accept when the selected slot is empty or frees up this cycle; never
    // during reset so a word offered then is discarded.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (s) begin
            in_ready_s = !out1_valid || drain1_s;
        end else begin
            in_ready_s = !out0_valid || drain0_s;
        end
    end

    // Route an accepted word to exactly one slot.
    always_comb begin
        load0_s = 1'b0;
        load1_s = 1'b0;
        if (in_valid && in_ready_s) begin
            load0_s = !s;
            load1_s = s;
        end else begin
            load0_s = 1'b0;
            load1_s = 1'b0;
        end
    end

    assign in_ready = in_ready_s;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk   (clk),
        .rst   (rst),
        .load  (load0_s),
        .ready (out0_ready),
        .din   (a),
        .dout  (out0),
        .valid (out0_valid),
        .drain (drain0_s)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load1_s),
        .ready (out1_ready),
        .din   (a),
        .dout  (out1),
        .valid (out1_valid),
        .drain (drain1_s)
    );

`ifdef DEMUX32_XFER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt0_r;
    logic [CNT_WIDTH-1:0] cnt1_r;

    // Per-port output transfer counters, wrapping modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (drain0_s) begin
                cnt0_r <= cnt_next(cnt0_r);
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (drain1_s) begin
                cnt1_r <= cnt_next(cnt1_r);
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule

// File: doc/demux32_1_2_buf.md
DEMUX32_1_2_BUF -- requirements
Module: demux32_1_2_buf

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and sets the data width.
REQ-002 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-004 a  input  WIDTH  is the source data word.
REQ-005 s  input  1  is the destination select; 0 routes to port 0 and 1 routes to port 1.
REQ-006 in_valid  input  1  SHALL indicate that a and s are valid this cycle.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts the word this cycle.
REQ-008 out0, out1  output  WIDTH each  are the destination data ports.
REQ-009 out0_valid, out1_valid  output  1 each  SHALL indicate that the matching data port holds a word.
REQ-010 out0_ready, out1_ready  input  1 each  are the destination accept signals.

Function
REQ-011 Each port SHALL own a one-entry slot with state EMPTY or FULL; outN_valid SHALL be 1 exactly when slot N is FULL.
REQ-012 A transfer on the input side SHALL occur when in_valid and in_ready are both 1; a transfer on the output side SHALL occur when outN_valid and outN_ready are both 1.
REQ-013 in_ready SHALL be 1 when the slot selected by s is EMPTY, or when it is FULL and draining this cycle. in_ready SHALL be combinational from s, the slot states and outN_ready.
REQ-014 An accepted word SHALL appear on the selected outN, with outN_valid=1, in the next cycle (latency 1); the other slot SHALL be unaffected.
REQ-015 Slot transitions SHALL be:
- EMPTY to FULL on load.
- FULL to EMPTY on drain without load.
- FULL stays FULL on simultaneous drain and load, holding the new word.
- Otherwise the slot SHALL hold its state.
REQ-016 outN SHALL hold its value, unchanged, while slot N is FULL and not draining; outN SHALL be 0 while slot N is EMPTY.
REQ-017 Ordering SHALL be preserved per port; no ordering guarantee SHALL exist across ports.
REQ-018 Both ports SHALL be able to drain in the same cycle, independently.
REQ-019 The values of s and a SHALL be ignored when in_valid is 0.
REQ-020 No word SHALL be dropped or duplicated, whatever the backpressure pattern.

Reset
REQ-021 While rst is 1 at a clock edge, both slots SHALL go to EMPTY, out0/out1 SHALL be 0, and the counters (when present) SHALL be 0.
REQ-022 While rst is 1, in_ready SHALL be 0; any word offered during that cycle SHALL be discarded.
REQ-023 A reset asserted mid-operation SHALL flush held words without producing any outN_valid pulse in the following cycle.

Configuration
REQ-024 With macro DEMUX32_XFER_CNT_EN defined, the block SHALL add outputs cnt0 and cnt1, 16 bits each. Each SHALL count output transfers on its port, wrap from 0xFFFF to 0x0000, and be cleared by rst.
REQ-025 Without DEMUX32_XFER_CNT_EN, those ports and registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package demux_pkg SHALL hold:
- the slot-state encoding: EMPTY=1'b0, FULL=1'b1;
- the WIDTH default of 32;
- the counter width of 16.
REQ-027 The single slot (state bit plus WIDTH data register plus load/drain logic) SHALL be a sub-module demux_slot, instantiated twice; top-level select and in_ready logic SHALL stay in demux32_1_2_buf.

Verification
REQ-028 After reset, drive a=32'hDEADBEEF, s=0, in_valid=1 with out0_ready=1 -> in_ready=1; next cycle out0=32'hDEADBEEF, out0_valid=1, out1_valid=0.
REQ-029 Send 32'h1 to port 1 with out1_ready=0, then offer 32'h2 to port 1 -> in_ready=0 and out1 holds 32'h1; raise out1_ready -> 32'h2 is accepted in that same cycle and appears on out1 next cycle.
REQ-030 Hold port 1 full and stalled, then send 32'hA5A5A5A5 with s=0 -> accepted; out0 shows it next cycle while out1 is unchanged.
REQ-031 Assert rst in the cycle after a load to port 0 -> out0_valid=0 and out0=0 the next cycle; in_ready=0 during reset.
REQ-032 Randomized s, in_valid and outN_ready for 10,000 cycles against a two-queue scoreboard -> zero mismatches, losses or duplicates.
REQ-033 With DEMUX32_XFER_CNT_EN defined, perform 65,537 transfers on port 0 -> cnt0=1 and cnt1=0.
